// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants of the pseudo-random number stream.
//   RND_NUM_W : width of the LFSR output word handed to its consumers.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int RND_NUM_W = 16;

endpackage : lfsr_pkg

// File: rtl/serve_pkg.sv
// -----------------------------------------------------------------------------
// serve_pkg
// Types and default constants for the serve randomizer.
//   serve_state_t : IDLE (waiting for a serve), DRAW (sampling the LFSR),
//                   HOLD (velocity pair presented on the valid/ready port).
//   DEF_*         : default velocity and sampling parameters.
// -----------------------------------------------------------------------------
package serve_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } serve_state_t;

    localparam int DEF_VEL_W      = 5;
    localparam int DEF_VX_SPEED   = 4;
    localparam int DEF_VY_MIN     = 1;
    localparam int DEF_VY_MAX     = 5;
    localparam int DEF_MAX_TRIES  = 4;
    localparam int DEF_SAMPLE_GAP = 4;

endpackage : serve_pkg

// File: rtl/serve_sample_check.sv
// -----------------------------------------------------------------------------
// serve_sample_check
// Combinational evaluation of one LFSR sample: splits it into magnitude and
// sign, decides whether the sample is usable and produces the signed vertical
// velocity that would be committed.
// Build option: SERVE_REJECT_EN
//   defined   : out-of-range samples are rejected; on the last try the
//               magnitude falls back to VY_MIN with the sample's sign.
//   undefined : every sample is accepted, magnitude clamped to [VY_MIN,VY_MAX].
// Ports:
//   field_i    in  MAG_W+1 : {sign, magnitude} bits of the LFSR word
//   last_try_i in  1       : current sample is the final allowed try
//                            (SERVE_REJECT_EN builds only)
//   accept_o   out 1       : commit this sample's velocity now
//   vel_y_o    out VEL_W   : signed vertical velocity for this sample
// -----------------------------------------------------------------------------
module serve_sample_check #(
    parameter int VEL_W  = 5,
    parameter int VY_MIN = 1,
    parameter int VY_MAX = 5,
    parameter int MAG_W  = $clog2(VY_MAX + 1)
) (
    input  logic [MAG_W:0]           field_i,
`ifdef SERVE_REJECT_EN
    input  logic                     last_try_i,
`endif
    output logic                     accept_o,
    output logic signed [VEL_W-1:0]  vel_y_o
);

    localparam logic [MAG_W-1:0] MIN_M = MAG_W'(VY_MIN);
    localparam logic [MAG_W-1:0] MAX_M = MAG_W'(VY_MAX);

    logic [MAG_W-1:0] mag;
    logic             sign;
    logic [MAG_W-1:0] mag_sel;
    logic [VEL_W-1:0] mag_ext;

    assign mag  = field_i[MAG_W-1:0];
    assign sign = field_i[MAG_W];

`ifdef SERVE_REJECT_EN
    logic in_range;
    assign in_range = (mag >= MIN_M) && (mag <= MAX_M);
`endif

    always_comb begin
        mag_sel = mag;
`ifdef SERVE_REJECT_EN
        // The fallback keeps the sample's sign so the vertical direction
        // stays random even when every magnitude was rejected.
        accept_o = in_range || last_try_i;
        if (!in_range) begin
            mag_sel = MIN_M;
        end
`else
        accept_o = 1'b1;
        if (mag < MIN_M) begin
            mag_sel = MIN_M;
        end else if (mag > MAX_M) begin
            mag_sel = MAX_M;
        end
`endif
    end

    assign mag_ext = VEL_W'(mag_sel);
    assign vel_y_o = sign ? -mag_ext : mag_ext;

endmodule : serve_sample_check

// File: rtl/serve_randomizer.sv
// -----------------------------------------------------------------------------
// serve_randomizer
// Turns the LFSR stream into a bounded, signed initial ball velocity on each
// serve request and hands it to the physics block over valid/ready.
// Build option: SERVE_REJECT_EN
//   defined   : rejection sampling, up to MAX_TRIES samples spaced SAMPLE_GAP
//               cycles apart so every sample uses fresh LFSR bits.
//   undefined : single clamped sample; try/gap counters are not built.
// Ports:
//   clk_i       in  1         : clock
//   rst_i       in  1         : synchronous active-high reset
//   rnd_num_i   in  RND_NUM_W : LFSR output
//   serve_req_i in  1         : start a draw (level, looked at in IDLE only)
//   side_i      in  1         : 0 = ball moves +x, 1 = ball moves -x
//   valid_o     out 1         : velocity pair valid
//   ready_i     in  1         : consumer accepts
//   vel_x_o     out VEL_W     : signed horizontal velocity
//   vel_y_o     out VEL_W     : signed vertical velocity
//   busy_o      out 1         : a draw or hand-over is in progress
// -----------------------------------------------------------------------------
module serve_randomizer
    import lfsr_pkg::*;
    import serve_pkg::*;
#(
    parameter int VEL_W      = DEF_VEL_W,
    parameter int VX_SPEED   = DEF_VX_SPEED,
    parameter int VY_MIN     = DEF_VY_MIN,
    parameter int VY_MAX     = DEF_VY_MAX,
    parameter int MAX_TRIES  = DEF_MAX_TRIES,
    parameter int SAMPLE_GAP = DEF_SAMPLE_GAP
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [RND_NUM_W-1:0]        rnd_num_i,
    input  logic                        serve_req_i,
    input  logic                        side_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [VEL_W-1:0]     vel_x_o,
    output logic signed [VEL_W-1:0]     vel_y_o,
    output logic                        busy_o
);

    localparam int MAG_W = $clog2(VY_MAX + 1);
    localparam logic signed [VEL_W-1:0] VX_POS = VEL_W'(VX_SPEED);
    localparam logic signed [VEL_W-1:0] VX_NEG = VEL_W'(-VX_SPEED);

    // Elaboration-time parameter sanity checks.
    if (RND_NUM_W < MAG_W + 1) begin : g_chk_rnd_w
        $error("serve_randomizer: RND_NUM_W too narrow for magnitude and sign");
    end
    if ((VY_MAX >= 2 ** (VEL_W - 1)) || (VX_SPEED >= 2 ** (VEL_W - 1))) begin : g_chk_vel_w
        $error("serve_randomizer: velocity does not fit signed VEL_W");
    end
    if ((MAX_TRIES < 1) || (SAMPLE_GAP < 1) || (VY_MIN > VY_MAX)) begin : g_chk_draw
        $error("serve_randomizer: invalid sampling parameters");
    end

    // Only the magnitude and sign bits of the LFSR word are consumed.
    if (RND_NUM_W > MAG_W + 1) begin : g_rnd_unused
        logic unused_rnd;
        assign unused_rnd = ^rnd_num_i[RND_NUM_W-1:MAG_W+1];
    end

    serve_state_t            state_q, state_d;
    logic                    side_q, side_d;
    logic signed [VEL_W-1:0] vel_x_q, vel_x_d;
    logic signed [VEL_W-1:0] vel_y_q, vel_y_d;
    logic                    sample_accept;
    logic signed [VEL_W-1:0] sample_vel_y;

`ifdef SERVE_REJECT_EN
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP - 1);

    logic [TRY_W-1:0] tries_q, tries_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             last_try;

    assign last_try = (tries_q == LAST_TRY);
`endif

    serve_sample_check #(
        .VEL_W  (VEL_W),
        .VY_MIN (VY_MIN),
        .VY_MAX (VY_MAX),
        .MAG_W  (MAG_W)
    ) u_sample_check (
        .field_i    (rnd_num_i[MAG_W:0]),
`ifdef SERVE_REJECT_EN
        .last_try_i (last_try),
`endif
        .accept_o   (sample_accept),
        .vel_y_o    (sample_vel_y)
    );

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
`ifdef SERVE_REJECT_EN
        tries_d = tries_q;
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (serve_req_i) begin
                    side_d  = side_i;
`ifdef SERVE_REJECT_EN
                    tries_d = '0;
                    gap_d   = '0;
`endif
                    state_d = DRAW;
                end
            end
            DRAW: begin
`ifdef SERVE_REJECT_EN
                // The LFSR shifts one bit per cycle, so waiting SAMPLE_GAP
                // cycles between samples keeps them from sharing bits.
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (sample_accept) begin
                    vel_x_d = side_q ? VX_NEG : VX_POS;
                    vel_y_d = sample_vel_y;
                    state_d = HOLD;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                    gap_d   = GAP_LOAD;
                end
`else
                if (sample_accept) begin
                    vel_x_d = side_q ? VX_NEG : VX_POS;
                    vel_y_d = sample_vel_y;
                    state_d = HOLD;
                end
`endif
            end
            HOLD: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            side_q  <= 1'b0;
            vel_x_q <= '0;
            vel_y_q <= '0;
`ifdef SERVE_REJECT_EN
            tries_q <= '0;
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
`ifdef SERVE_REJECT_EN
            tries_q <= tries_d;
            gap_q   <= gap_d;
`endif
        end
    end

    // All outputs come straight from registers, so ready_i never reaches them
    // combinationally.
    assign valid_o = (state_q == HOLD);
    assign busy_o  = (state_q != IDLE);
    assign vel_x_o = vel_x_q;
    assign vel_y_o = vel_y_q;

endmodule : serve_randomizer

// File: tb/tb_serve_randomizer.sv
// -----------------------------------------------------------------------------
// tb_serve_randomizer
// Self-checking bench for serve_randomizer. A driver issues serves with a
// prepared per-cycle LFSR sequence and pushes the expected velocity pair and
// latency into a queue; a monitor pops and compares whenever valid_o rises,
// and checks output stability in HOLD and the return to IDLE after handshake.
// Follows SERVE_REJECT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_serve_randomizer;
    import lfsr_pkg::*;

    localparam int VEL_W      = 5;
    localparam int VX_SPEED   = 4;
    localparam int VY_MIN     = 1;
    localparam int VY_MAX     = 5;
    localparam int MAX_TRIES  = 4;
    localparam int SAMPLE_GAP = 4;
    localparam int MAG_W      = $clog2(VY_MAX + 1);
    localparam int SEQ_N      = 24;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [RND_NUM_W-1:0]     rnd_num_i;
    logic                     serve_req_i;
    logic                     side_i;
    logic                     valid_o;
    logic                     ready_i;
    logic signed [VEL_W-1:0]  vel_x_o;
    logic signed [VEL_W-1:0]  vel_y_o;
    logic                     busy_o;

    always #5 clk = ~clk;

    serve_randomizer #(
        .VEL_W      (VEL_W),
        .VX_SPEED   (VX_SPEED),
        .VY_MIN     (VY_MIN),
        .VY_MAX     (VY_MAX),
        .MAX_TRIES  (MAX_TRIES),
        .SAMPLE_GAP (SAMPLE_GAP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rnd_num_i   (rnd_num_i),
        .serve_req_i (serve_req_i),
        .side_i      (side_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .vel_x_o     (vel_x_o),
        .vel_y_o     (vel_y_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic signed [VEL_W-1:0] vx;
        logic signed [VEL_W-1:0] vy;
        int                      lat;
        time                     t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [RND_NUM_W-1:0] seq_buf [SEQ_N];

    task automatic check_eq(input string name, input logic signed [31:0] act,
                            input logic signed [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference: which sample is used and what it yields, straight from the
    // serve rules (sample k of the draw sits at cycle 1 + k*SAMPLE_GAP).
    function automatic void model(output int vy, output int lat);
        int mag;
        int sgn;
        logic [RND_NUM_W-1:0] s;
        vy  = 0;
        lat = 0;
`ifdef SERVE_REJECT_EN
        for (int t = 0; t < MAX_TRIES; t++) begin
            s   = seq_buf[1 + t * SAMPLE_GAP];
            mag = int'(s) % (2 ** MAG_W);
            sgn = int'(s[MAG_W]);
            lat = 2 + t * SAMPLE_GAP;
            if (mag >= VY_MIN && mag <= VY_MAX) begin
                vy = sgn ? -mag : mag;
                return;
            end
            vy = sgn ? -VY_MIN : VY_MIN;
        end
`else
        s   = seq_buf[1];
        mag = int'(s) % (2 ** MAG_W);
        sgn = int'(s[MAG_W]);
        if (mag < VY_MIN) mag = VY_MIN;
        if (mag > VY_MAX) mag = VY_MAX;
        vy  = sgn ? -mag : mag;
        lat = 2;
`endif
    endfunction

    task automatic fill_const(input logic [3:0] lo);
        logic [RND_NUM_W-1:0] r;
        for (int k = 0; k < SEQ_N; k++) begin
            r = RND_NUM_W'($urandom);
            r[3:0] = lo;
            seq_buf[k] = r;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < SEQ_N; k++) seq_buf[k] = RND_NUM_W'($urandom);
    endtask

    // Called just after a rising edge. Issues one serve, waits for valid,
    // keeps ready low for 'hold' cycles (pulsing serve_req), then handshakes.
    task automatic serve(input bit side, input int hold, input bit early_ready,
                         input int exp_vy, input int exp_lat);
        exp_t e;
        bit   seen;
        int   k;
        serve_req_i = 1'b1;
        side_i      = side;
        ready_i     = early_ready;
        rnd_num_i   = seq_buf[0];
        @(posedge clk);
        e.t0  = $time;
        e.vx  = side ? VEL_W'(-VX_SPEED) : VEL_W'(VX_SPEED);
        e.vy  = VEL_W'(exp_vy);
        e.lat = exp_lat;
        exp_q.push_back(e);
        #1;
        seen = 1'b0;
        k    = 1;
        while (!seen && k < 40) begin
            serve_req_i = 1'($urandom_range(0, 1));
            side_i      = 1'($urandom_range(0, 1));
            rnd_num_i   = (k < SEQ_N) ? seq_buf[k] : RND_NUM_W'($urandom);
            @(posedge clk);
            #1;
            k++;
            seen = (valid_o === 1'b1);
        end
        if (!seen) check_eq("valid_timeout", 0, 1);
        for (int h = 0; h < hold; h++) begin
            ready_i     = 1'b0;
            serve_req_i = 1'($urandom_range(0, 1));
            side_i      = 1'($urandom_range(0, 1));
            rnd_num_i   = RND_NUM_W'($urandom);
            @(posedge clk);
            #1;
        end
        ready_i     = 1'b1;
        serve_req_i = 1'b0;
        rnd_num_i   = RND_NUM_W'($urandom);
        @(posedge clk);
        #1;
        ready_i     = 1'b0;
    endtask

    // Monitor: scoreboard pop on valid rise, stability while held, IDLE after
    // each completed handshake.
    initial begin
        exp_t cur;
        bit   prev_valid = 1'b0;
        bit   hs_pending = 1'b0;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst_i !== 1'b0) begin
                prev_valid = 1'b0;
                hs_pending = 1'b0;
            end else begin
                if (hs_pending) begin
                    check_eq("valid_after_hs", valid_o, 0);
                    check_eq("busy_after_hs", busy_o, 0);
                    hs_pending = 1'b0;
                end
                if (valid_o === 1'b1 && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_valid", valid_o, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        lat = int'(($time - cur.t0 + 5) / 10);
                        $display("serve: vel_x=%0d vel_y=%0d latency=%0d", vel_x_o, vel_y_o, lat);
                        check_eq("vel_x", vel_x_o, cur.vx);
                        check_eq("vel_y", vel_y_o, cur.vy);
                        check_eq("latency", lat, cur.lat);
                        check_eq("busy_in_hold", busy_o, 1);
                    end
                end else if (valid_o === 1'b1) begin
                    check_eq("vel_x_stable", vel_x_o, cur.vx);
                    check_eq("vel_y_stable", vel_y_o, cur.vy);
                end
                if (valid_o === 1'b1 && ready_i === 1'b1) hs_pending = 1'b1;
                prev_valid = (valid_o === 1'b1);
            end
        end
    end

    initial begin
        int  vy;
        int  lat;
        bit  side;
        bit  early;
        int  hold;
        rst_i       = 1'b1;
        rnd_num_i   = '0;
        serve_req_i = 1'b0;
        side_i      = 1'b0;
        ready_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_vel_x", vel_x_o, 0);
        check_eq("rst_vel_y", vel_y_o, 0);
        check_eq("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // mag 3, sign 0, side 0; ready held off 5 cycles with serve pulses
        fill_const(4'b0011);
        serve(1'b0, 5, 1'b0, 3, 2);

        // mag 5, sign 1, side 1
        fill_const(4'b1101);
        serve(1'b1, 0, 1'b0, -5, 2);

        // out-of-range 7 for the first sample, 2 from cycle 5 on
        fill_const(4'b0111);
        for (int k = 5; k < SEQ_N; k++) seq_buf[k][3:0] = 4'b0010;
`ifdef SERVE_REJECT_EN
        serve(1'b0, 1, 1'b0, 2, 6);
`else
        serve(1'b0, 1, 1'b0, 5, 2);
`endif

        // mag 0 with sign set forever: fallback / clamp to -VY_MIN
        fill_const(4'b1000);
`ifdef SERVE_REJECT_EN
        serve(1'b0, 0, 1'b1, -1, 14);
`else
        serve(1'b0, 0, 1'b1, -1, 2);
`endif

        // reset in the middle of a draw: no output may ever appear
        fill_random();
        serve_req_i = 1'b1;
        side_i      = 1'b1;
        rnd_num_i   = seq_buf[0];
        @(posedge clk);
        #1;
        serve_req_i = 1'b0;
        rnd_num_i   = seq_buf[1];
        check_eq("busy_in_draw", busy_o, 1);
        rst_i = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_i = 1'b0;
        repeat (16) begin
            rnd_num_i = RND_NUM_W'($urandom);
            @(posedge clk);
            #1;
        end
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_vel_x", vel_x_o, 0);
        check_eq("midrst_vel_y", vel_y_o, 0);

        // randomized serves against the reference model
        for (int n = 0; n < 40; n++) begin
            fill_random();
            side  = 1'($urandom_range(0, 1));
            early = ($urandom_range(0, 3) == 0);
            hold  = early ? 0 : int'($urandom_range(0, 4));
            model(vy, lat);
            serve(side, hold, early, vy, lat);
        end

        repeat (4) @(posedge clk);
        #1;
        check_eq("pending_outputs", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serve_randomizer
